uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Parametrised UART receive engine for the APB UART peripheral. Runs entirely on `PCLK`:
- generates its own 16x oversampling tick from a programmable divisor;
- de-glitches `RXD` with majority voting;
- supports 5–8 data bits, none/even/odd parity and 1 or 2 stop bits;
- stores each frame plus its error flags in a parametrised show-ahead FIFO;
- sits between the pad-side `RXD` and the APB register block, which pops the FIFO on reads of the data register.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: number of receive entries (power of two, ≥2).
- `DIV_W`, 16: width of the oversample divisor.

Ports:
- `PCLK` in 1: sole clock.
- `PRESETn` in 1: reset, asynchronous, active-low.
- `cfg_div` in DIV_W: `PCLK` cycles per oversample tick; 0 is treated as 1.
- `cfg_data_bits` in 2: data bits per frame = 5 + value.
- `cfg_parity` in 2: 00 none, 01 even, 10 odd, 11 none.
- `cfg_stop2` in 1: 1 = two stop bits.
- `rxd_i` in 1: asynchronous serial input, idles high.
- `rd_en` in 1: pop FIFO head.
- `rd_data` out 8: head data; LSB-aligned, upper bits 0 for shorter frames.
- `rd_err` out 3: head flags; [0] parity error, [1] framing error, [2] break.
- `empty` out 1; `full` out 1.
- `count` out $clog2(FIFO_DEPTH+1): number of entries stored.
- `overrun` out 1: sticky, set when a frame is dropped.
- `clr_overrun` in 1: clears `overrun`.
- `busy` out 1: 1 whenever the FSM is not in IDLE.

## Operation
- `rxd_i` passes through a 2-FF synchronizer (resets to 1) to give `rxd_s`.
- Tick counter counts 0..max(`cfg_div`,1)−1; `tick` pulses for one `PCLK` cycle at wrap. The tick counter free-runs. The oversample counter `os_cnt` (0..15) advances on `tick`.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE:
  - On `rxd_s`==0: latch the cfg_* inputs for the whole frame, clear `os_cnt`, go to START.
  - Config changes mid-frame have no effect until the next frame.
- Bit sampling: on each bit, take samples at `os_cnt` 7, 8 and 9; the voted bit is the majority of the three.
- START: at tick 9, if the vote is 1 (false start), return to IDLE and push nothing. Otherwise, at tick 15 go to DATA with bit index 0.
- DATA: the vote shifts in LSB first. At tick 15 of the last data bit, go to PARITY if parity is enabled, else STOP1.
- PARITY:
  - The vote is compared against the XOR of the data bits: even mode expects that XOR; odd mode expects its complement.
  - A mismatch sets the parity error flag.
- STOP1 / STOP2:
  - A vote of 0 in any stop bit sets the framing error flag.
  - At tick 9 of the final stop bit (STOP2 if `cfg_stop2`, else STOP1), push {err, data} and go straight to IDLE, so the receiver can resync on an early next start bit.
- Break: set when data, parity (if enabled) and the final stop bit all sampled 0.
- FIFO:
  - Show-ahead: `rd_data`/`rd_err` always reflect the head.
  - `rd_en` while `empty` is ignored.
  - A push while `full` with no simultaneous pop drops the frame and sets `overrun`.
  - A push and pop in the same cycle while full both succeed; `count` is unchanged and `overrun` is not set.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- `overrun`: if set and clear occur in the same cycle, set wins.

## Timing
- Reset values: `rd_data`=0, `rd_err`=0, `empty`=1, `full`=0, `count`=0, `overrun`=0, `busy`=0. The FSM is in IDLE, all counters are 0 and the synchronizer holds 1s.
- Asserting reset mid-frame aborts the frame; no partial push occurs.
- `rxd_i` fall to FSM leaving IDLE: 3 `PCLK` edges.
- Push to `count`/`empty` update: 1 `PCLK` edge. `rd_en` to the next head being visible: 1 edge.
- Bit period = 16 × max(`cfg_div`,1) `PCLK` cycles.

## Configuration
- `UART_RX_BREAK_DETECT_EN` defined: break detection is built and sets `rd_err[2]`.
- Not defined: `rd_err[2]` is tied to 0 and the break compare logic is absent; all other behaviour is identical.

## Structure
- Package `uart_pkg`: parity enum (`PAR_NONE`/`PAR_EVEN`/`PAR_ODD`), FSM state enum, and `OS_RATE`=16, `SAMPLE_LO`=7, `SAMPLE_HI`=9.
- Sub-module `uart_rx_fifo`: generic show-ahead sync FIFO parametrised on width (11) and depth. It provides `full`/`empty`/`count` and the simultaneous push/pop rule.

## Test plan
- Frame 0x6D: `cfg_div`=4, 8 bits, even parity, 2 stop bits, sent with parity bit 1 → `rd_data`=0x6D, `rd_err`=000, `count`=1, `rd_en` → `empty`=1.
- Bad parity: send 0x79 in odd mode with parity bit 1 → `rd_data`=0x79, `rd_err`=001.
- Glitch: `rxd_i` low for 16 cycles at `cfg_div`=4 (4 ticks) → no push, `busy` returns to 0, `count`=0.
- Framing error: 5-bit frame 0x15, stop bit 0 → `rd_data`=0x15, `rd_err[1]`=1.
- Overrun: `FIFO_DEPTH`=4, five frames 0x01..0x05 with no reads → `count`=4, `full`=1, `overrun`=1. Reads return 0x01..0x04; `clr_overrun` → `overrun`=0.
- Reset mid-DATA, then a clean 0x48 frame → only 0x48 stored. With `UART_RX_BREAK_DETECT_EN`, an all-zero frame → `rd_err`=110 with parity off.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: parity modes, receiver
// FSM states and oversampling parameters.
package uart_pkg;

    localparam int OS_RATE   = 16;
    localparam int SAMPLE_LO = 7;
    localparam int SAMPLE_HI = 9;
    localparam int OS_W      = $clog2(OS_RATE);
    localparam int ENTRY_W   = 11;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rx_state_t;

    // Encoding 2'b11 is reserved and behaves as no parity.
    function automatic parity_t decode_parity(input logic [1:0] cfg);
        case (cfg)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic show-ahead synchronous FIFO; the head entry is always visible on rdata.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: 16x oversampling, 3-sample majority vote, 5-8 data bits,
// optional parity, 1/2 stop bits, frames queued in a show-ahead FIFO.
// Optional break detection on rd_err[2] is built when UART_RX_BREAK_DETECT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a low level on the synchronized line
// START  | validating the start bit; a high vote is a false start
// DATA   | shifting in data bits, LSB first
// PARITY | comparing the parity bit against the data XOR
// STOP1  | first stop bit; pushes here when one stop bit is configured
// STOP2  | second stop bit; always the final one when present
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                            PCLK,
    input  logic                            PRESETn,
    input  logic [DIV_W-1:0]                cfg_div,
    input  logic [1:0]                      cfg_data_bits,
    input  logic [1:0]                      cfg_parity,
    input  logic                            cfg_stop2,
    input  logic                            rxd_i,
    input  logic                            rd_en,
    output logic [7:0]                      rd_data,
    output logic [2:0]                      rd_err,
    output logic                            empty,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            overrun,
    input  logic                            clr_overrun,
    output logic                            busy
);

    rx_state_t            state;
    logic                 rxd_meta;
    logic                 rxd_s;
    logic [DIV_W-1:0]     div_cnt;
    logic [DIV_W-1:0]     div_lat;
    logic [DIV_W-1:0]     div_src;
    logic [DIV_W-1:0]     div_max;
    logic                 tick;
    logic [OS_W-1:0]      os_cnt;
    logic [1:0]           smp;
    logic                 vote;
    logic                 at_hi;
    logic                 at_end;
    logic [2:0]           last_idx;
    parity_t              par_lat;
    logic                 stop2_lat;
    logic [2:0]           bit_idx;
    logic [7:0]           data_sr;
    logic                 par_acc;
    logic                 perr;
    logic                 ferr;
    logic                 all_zero;
    logic                 brk;
    logic                 push_q;
    logic [ENTRY_W-1:0]   push_word;
    logic [ENTRY_W-1:0]   head;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd_i;
            rxd_s    <= rxd_meta;
        end
    end

    // The live divisor only matters while idle; a frame runs on its latched copy.
    assign div_src = (state == IDLE) ? cfg_div : div_lat;
    assign div_max = (div_src == '0) ? DIV_W'(1) : div_src;
    assign tick    = (div_cnt >= div_max - DIV_W'(1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) div_cnt <= '0;
        else          div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end

    assign vote   = (smp[0] & smp[1]) | (smp[0] & rxd_s) | (smp[1] & rxd_s);
    assign at_hi  = tick && (os_cnt == OS_W'(SAMPLE_HI));
    assign at_end = tick && (os_cnt == OS_W'(OS_RATE - 1));

`ifdef UART_RX_BREAK_DETECT_EN
    assign brk = all_zero & ~vote;
`else
    assign brk = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            os_cnt    <= '0;
            smp       <= '0;
            div_lat   <= '0;
            last_idx  <= '0;
            par_lat   <= PAR_NONE;
            stop2_lat <= 1'b0;
            bit_idx   <= '0;
            data_sr   <= '0;
            par_acc   <= 1'b0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            all_zero  <= 1'b0;
            push_q    <= 1'b0;
            push_word <= '0;
        end else begin
            push_q <= 1'b0;
            if (tick) os_cnt <= os_cnt + OS_W'(1);
            if (tick && os_cnt == OS_W'(SAMPLE_LO))     smp[0] <= rxd_s;
            if (tick && os_cnt == OS_W'(SAMPLE_LO + 1)) smp[1] <= rxd_s;

            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        div_lat   <= cfg_div;
                        last_idx  <= 3'd4 + {1'b0, cfg_data_bits};
                        par_lat   <= decode_parity(cfg_parity);
                        stop2_lat <= cfg_stop2;
                        os_cnt    <= '0;
                        bit_idx   <= '0;
                        data_sr   <= '0;
                        par_acc   <= 1'b0;
                        perr      <= 1'b0;
                        ferr      <= 1'b0;
                        all_zero  <= 1'b1;
                        state     <= START;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (at_hi && vote) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (at_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (at_hi) begin
                        data_sr[bit_idx] <= vote;
                        par_acc          <= par_acc ^ vote;
                        if (vote) all_zero <= 1'b0;
                    end
                    if (at_end) begin
                        if (bit_idx == last_idx)
                            state <= (par_lat != PAR_NONE) ? PARITY : STOP1;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end
                end
                PARITY: begin
                    if (at_hi) begin
                        perr <= (vote != (par_acc ^ (par_lat == PAR_ODD)));
                        if (vote) all_zero <= 1'b0;
                    end
                    if (at_end) state <= STOP1;
                end
                STOP1: begin
                    if (at_hi) begin
                        ferr <= ferr | ~vote;
                        if (!stop2_lat) begin
                            push_q    <= 1'b1;
                            push_word <= {brk, ferr | ~vote, perr, data_sr};
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end
                    end else if (at_end && stop2_lat) begin
                        state <= STOP2;
                    end
                end
                STOP2: begin
                    // Return early so an immediate next start bit is not missed.
                    if (at_hi) begin
                        push_q    <= 1'b1;
                        push_word <= {brk, ferr | ~vote, perr, data_sr};
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (push_q),
        .wdata (push_word),
        .pop   (rd_en),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign rd_data = head[7:0];
    assign rd_err  = head[10:8];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                    overrun <= 1'b0;
        else if (push_q && full && !rd_en) overrun <= 1'b1;
        else if (clr_overrun)            overrun <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed plus randomized bench for uart_rx_core; expected frames come from a
// bit-level model of the serial format (break bit modelled when UART_RX_BREAK_DETECT_EN is set).
module tb_uart_rx_core;

    localparam int DEPTH = 4;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [15:0] cfg_div = 16'd4;
    logic [1:0]  cfg_data_bits = 2'd3;
    logic [1:0]  cfg_parity = 2'd0;
    logic        cfg_stop2 = 1'b0;
    logic        rxd_i = 1'b1;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic [2:0]  rd_err;
    logic        empty;
    logic        full;
    logic [2:0]  count;
    logic        overrun;
    logic        clr_overrun = 1'b0;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx_core #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .cfg_div       (cfg_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .rxd_i         (rxd_i),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_err        (rd_err),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .overrun       (overrun),
        .clr_overrun   (clr_overrun),
        .busy          (busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    function automatic int bit_cycles();
        return 16 * ((cfg_div == 16'd0) ? 1 : int'(cfg_div));
    endfunction

    // Expected {break, framing, parity, data} from the line-level frame contents.
    function automatic logic [10:0] model(input logic [7:0] d, input logic [1:0] db,
                                          input logic [1:0] par, input logic pbit,
                                          input logic s1, input logic s2, input logic st2);
        int         nb = 5 + int'(db);
        logic [7:0] m = 8'(d & 8'((1 << nb) - 1));
        logic       x = ^m;
        logic       pe = 1'b0;
        logic       fe;
        logic       fin;
        logic       br = 1'b0;
        if (par == 2'b01) pe = (pbit != x);
        if (par == 2'b10) pe = (pbit != !x);
        fe  = !s1 || (st2 && !s2);
        fin = st2 ? s2 : s1;
`ifdef UART_RX_BREAK_DETECT_EN
        br = (m == 8'd0) && ((par == 2'b00 || par == 2'b11) || !pbit) && !fin;
`endif
        return {br, fe, pe, m};
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic [1:0] db, input logic [1:0] par,
                              input logic pbit, input logic s1, input logic s2, input logic st2);
        int bc;
        cfg_data_bits = db;
        cfg_parity    = par;
        cfg_stop2     = st2;
        bc = bit_cycles();
        rxd_i = 1'b0;
        cycles(bc);
        for (int i = 0; i < 5 + int'(db); i++) begin
            rxd_i = d[i];
            cycles(bc);
        end
        if (par == 2'b01 || par == 2'b10) begin
            rxd_i = pbit;
            cycles(bc);
        end
        rxd_i = s1;
        cycles(bc);
        if (st2) begin
            rxd_i = s2;
            cycles(bc);
        end
        rxd_i = 1'b1;
        cycles(2 * bc);
    endtask

    task automatic wait_count(input int n);
        int k = 0;
        while (count != n[2:0] && k < 3000) begin
            cycles(1);
            k++;
        end
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
    endtask

    initial begin
        logic [10:0] exp;
        logic [7:0]  rd;
        logic [1:0]  rdb;
        logic [1:0]  rpar;
        logic        rpb;
        logic        rs1;
        logic        rs2;
        logic        rst2;

        cycles(3);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        PRESETn = 1'b1;
        cycles(5);

        // 0x6D, 8 bits, even parity, two stop bits
        cfg_div = 16'd4;
        exp = model(8'h6D, 2'd3, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1);
        send_frame(8'h6D, 2'd3, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_count(1);
        chk("f6d_count", count, 1);
        chk("f6d_data", rd_data, exp[7:0]);
        chk("f6d_err", rd_err, exp[10:8]);
        chk("f6d_err_const", rd_err, 3'b000);
        pop();
        chk("f6d_empty_after_pop", empty, 1);

        // 0x79 odd parity with parity bit 1 is a parity error
        send_frame(8'h79, 2'd3, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_count(1);
        chk("f79_data", rd_data, 8'h79);
        chk("f79_err", rd_err, 3'b001);
        pop();

        // 16-cycle glitch at div 4 is a false start
        rxd_i = 1'b0;
        cycles(16);
        rxd_i = 1'b1;
        cycles(4);
        chk("glitch_busy_rise", busy, 1);
        cycles(150);
        chk("glitch_busy_fall", busy, 0);
        chk("glitch_count", count, 0);

        // 5-bit 0x15 with a low stop bit
        send_frame(8'h15, 2'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_count(1);
        chk("ferr_data", rd_data, 8'h15);
        chk("ferr_flag", rd_err[1], 1);
        pop();
        cycles(100);
        chk("ferr_no_extra", count, 0);

        // overrun with five frames into four slots
        for (int i = 1; i <= 5; i++)
            send_frame(8'(i), 2'd3, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        cycles(10);
        chk("ovr_count", count, 4);
        chk("ovr_full", full, 1);
        chk("ovr_flag", overrun, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovr_read", rd_data, 16'(i));
            pop();
        end
        chk("ovr_empty", empty, 1);
        chk("ovr_sticky", overrun, 1);
        clr_overrun = 1'b1;
        cycles(1);
        clr_overrun = 1'b0;
        chk("ovr_cleared", overrun, 0);

        // reset in the middle of the data bits
        cfg_data_bits = 2'd3;
        cfg_parity    = 2'b00;
        cfg_stop2     = 1'b0;
        rxd_i = 1'b0;
        cycles(64);
        rxd_i = 1'b1;
        cycles(64);
        rxd_i = 1'b0;
        cycles(64);
        chk("midrst_busy", busy, 1);
        PRESETn = 1'b0;
        rxd_i   = 1'b1;
        cycles(3);
        chk("midrst_busy_rst", busy, 0);
        chk("midrst_count_rst", count, 0);
        PRESETn = 1'b1;
        cycles(10);
        send_frame(8'h48, 2'd3, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_count(1);
        chk("midrst_count", count, 1);
        chk("midrst_data", rd_data, 8'h48);
        chk("midrst_err", rd_err, 0);
        pop();

        // all-zero frame, no parity, low stop bit
        exp = model(8'h00, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h00, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_count(1);
        chk("brk_data", rd_data, exp[7:0]);
        chk("brk_err", rd_err, exp[10:8]);
        pop();
        cycles(100);
        chk("brk_no_extra", count, 0);

        // randomized frames and configurations
        for (int n = 0; n < 16; n++) begin
            cfg_div = 16'($urandom_range(0, 4));
            rd   = 8'($urandom);
            rdb  = 2'($urandom_range(0, 3));
            rpar = 2'($urandom_range(0, 3));
            rpb  = 1'($urandom_range(0, 1));
            rs1  = ($urandom_range(0, 5) != 0);
            rs2  = ($urandom_range(0, 5) != 0);
            rst2 = 1'($urandom_range(0, 1));
            exp  = model(rd, rdb, rpar, rpb, rs1, rs2, rst2);
            send_frame(rd, rdb, rpar, rpb, rs1, rs2, rst2);
            wait_count(1);
            chk("rnd_count", count, 1);
            chk("rnd_data", rd_data, exp[7:0]);
            chk("rnd_err", rd_err, exp[10:8]);
            pop();
            chk("rnd_empty", empty, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
